// File: rtl/ahb_blockram_ctrl.sv
// ahb_blockram_ctrl: zero-wait-state AHB-Lite slave for the Cortex-M0 dual-port block RAM.
// Define HAZARD_FWD_EN to forward write data into a colliding read; otherwise such reads stall one cycle.
module ahb_blockram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);
    typedef enum logic [1:0] {IDLE, ERR1, ERR2, STALL} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic                  wr_first_q, wr_first_d;
    logic                  rd_q, rd_d;
    logic                  accept, err, stall_go;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [31:0]           rd_word;
    logic                  unused;

    assign haddr_word = HADDR[ADDR_WIDTH+1:2];
    assign accept     = HSEL & HREADY & HTRANS[1];
    assign unused     = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    always_comb begin
        mask = (HSIZE == 3'd0) ? 4'b0001 << HADDR[1:0] :
               (HSIZE == 3'd1) ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        err  = (HSIZE > 3'd2) | ((HSIZE == 3'd1) & HADDR[0]) |
               ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    end

`ifdef HAZARD_FWD_EN
    logic [3:0]  fwd_mask_q, fwd_mask_d;
    logic [31:0] fwd_data_q, fwd_data_d;
    logic        hazard;
    assign stall_go = 1'b0;
    always_comb begin
        hazard     = accept & ~HWRITE & wr_first_q & (haddr_word == addr_q);
        fwd_mask_d = HREADY ? (hazard ? mask_q : 4'b0000) : fwd_mask_q;
        fwd_data_d = hazard ? HWDATA : fwd_data_q;
        rd_word    = doutb;
        for (int i = 0; i < 4; i++)
            rd_word[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : doutb[8*i +: 8];
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`else
    // Any read arriving during a write data phase waits for the write to land in the RAM.
    assign stall_go = accept & ~HWRITE & wr_first_q;
    assign rd_word  = doutb;
`endif

    always_comb begin
        addr_d     = accept ? haddr_word : addr_q;
        mask_d     = accept ? mask : mask_q;
        wr_first_d = accept & HWRITE & ~err;
        rd_d       = HREADY ? (accept & ~HWRITE & ~err) : rd_q;
        state_d    = (state_q == ERR1)  ? ERR2  :
                     (accept & err)     ? ERR1  :
                     stall_go           ? STALL : IDLE;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mask_q     <= 4'b0000;
            wr_first_q <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wr_first_q <= wr_first_d;
            rd_q       <= rd_d;
        end
    end

    assign HREADYOUT = ~((state_q == ERR1) | (state_q == STALL));
    assign HRESP     = (state_q == ERR1) | (state_q == ERR2);
    // During a stall the RAM re-reads the held read address after the write has committed.
    assign addrb     = (state_q == STALL) ? addr_q : haddr_word;
    assign addra     = addr_q;
    assign dina      = HWDATA;
    assign wea       = (wr_first_q & ~HRESET) ? mask_q : 4'b0000;
    assign HRDATA    = rd_q ? rd_word : 32'h0;
endmodule

// File: tb/tb_ahb_blockram_ctrl.sv
// tb_ahb_blockram_ctrl: directed bench with a behavioural block RAM; honours HAZARD_FWD_EN.
module tb_ahb_blockram_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA, dina, doutb;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADY, HREADYOUT, HRESP;
    logic [13:0] addra, addrb;
    logic [3:0]  wea;
    logic [31:0] mem [0:16383];
    int          n_chk = 0;
    int          n_fail = 0;

    ahb_blockram_ctrl #(.ADDR_WIDTH(14)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .addra(addra),
        .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
    );

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++)
            if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
        doutb <= mem[addrb];
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ap(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
    endtask

    task automatic idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        tick(); ap(1'b1, 3'd2, a);
        tick(); idle(); HWDATA = d;
    endtask

    initial begin
        HRESET = 1'b1; HWDATA = 32'h0; idle();
        tick(); tick();
        HRESET = 1'b0; #1;
        chk("rst_hreadyout", HREADYOUT, 1); chk("rst_hresp", HRESP, 0);
        chk("rst_wea", wea, 0);             chk("rst_hrdata", HRDATA, 0);
        wr_word(32'h04, 32'h0); wr_word(32'h20, 32'h0);
        wr_word(32'h24, 32'hCAFEF00D); wr_word(32'h30, 32'h0);
        // word write then read
        tick(); idle();
        tick(); ap(1'b1, 3'd2, 32'h10);
        tick(); idle(); HWDATA = 32'hDEADBEEF; #1;
        chk("w1_wea", wea, 4'hF); chk("w1_addra", addra, 4); chk("w1_dina", dina, 32'hDEADBEEF);
        tick(); ap(1'b0, 3'd2, 32'h10);
        tick(); idle(); #1;
        chk("r1_hrdata", HRDATA, 32'hDEADBEEF); chk("r1_hresp", HRESP, 0); chk("r1_ready", HREADYOUT, 1);
        // byte and halfword lanes
        tick(); ap(1'b1, 3'd2, 32'h10);
        tick(); HWDATA = 32'h11223344; ap(1'b1, 3'd0, 32'h13);
        tick(); HWDATA = 32'hAA000000; ap(1'b1, 3'd1, 32'h10); #1;
        chk("byte_wea", wea, 4'b1000);
        tick(); HWDATA = 32'h00005555; idle(); #1;
        chk("half_wea", wea, 4'b0011); chk("half_addra", addra, 4);
        tick(); ap(1'b0, 3'd2, 32'h10);
        tick(); idle(); #1;
        chk("merge_hrdata", HRDATA, 32'hAA225555);
        tick(); ap(1'b0, 3'd2, 32'h0001_0010); #1;
        chk("alias_addrb", addrb, 4);
        tick(); idle(); #1;
        chk("alias_hrdata", HRDATA, 32'hAA225555);
        // misaligned halfword, then misaligned word issued in ERR2
        tick(); ap(1'b0, 3'd1, 32'h01);
        tick(); idle(); #1;
        chk("e1_ready", HREADYOUT, 0); chk("e1_resp", HRESP, 1); chk("e1_wea", wea, 0);
        tick(); ap(1'b1, 3'd2, 32'h06); #1;
        chk("e2_ready", HREADYOUT, 1); chk("e2_resp", HRESP, 1);
        tick(); idle(); HWDATA = 32'hFFFFFFFF; #1;
        chk("e3_ready", HREADYOUT, 0); chk("e3_resp", HRESP, 1); chk("e3_wea", wea, 0);
        tick(); #1;
        chk("e4_ready", HREADYOUT, 1); chk("e4_resp", HRESP, 1);
        tick(); ap(1'b0, 3'd2, 32'h04); #1;
        chk("e5_resp", HRESP, 0);
        tick(); idle(); #1;
        chk("err_no_write", HRDATA, 32'h0);
        // same-word hazard
        tick(); ap(1'b1, 3'd2, 32'h20);
        tick(); HWDATA = 32'h12345678; ap(1'b0, 3'd2, 32'h20); #1;
        chk("hz_wea", wea, 4'hF);
        tick(); idle(); #1;
`ifdef HAZARD_FWD_EN
        chk("hz_ready", HREADYOUT, 1); chk("hz_hrdata", HRDATA, 32'h12345678);
`else
        chk("hz_stall_ready", HREADYOUT, 0); chk("hz_stall_wea", wea, 0);
        tick(); #1;
        chk("hz_ready", HREADYOUT, 1); chk("hz_hrdata", HRDATA, 32'h12345678);
`endif
        // write then read of a different word
        tick(); ap(1'b1, 3'd0, 32'h21);
        tick(); HWDATA = 32'h0000FF00; ap(1'b0, 3'd2, 32'h24); #1;
        chk("nm_wea", wea, 4'b0010);
        tick(); idle(); #1;
`ifndef HAZARD_FWD_EN
        chk("nm_stall_ready", HREADYOUT, 0);
        tick(); #1;
`endif
        chk("nm_hrdata", HRDATA, 32'hCAFEF00D);
        tick(); ap(1'b0, 3'd2, 32'h20);
        tick(); idle(); #1;
        chk("nm_word20", HRDATA, 32'h1234FF78);
        // reset during ERR1
        tick(); ap(1'b0, 3'd2, 32'h02);
        tick(); idle(); #1;
        chk("re_err1", HREADYOUT, 0);
        HRESET = 1'b1;
        tick(); HRESET = 1'b0; #1;
        chk("re_ready", HREADYOUT, 1); chk("re_resp", HRESP, 0);
        chk("re_wea", wea, 0);         chk("re_hrdata", HRDATA, 0);
        // reset during a write data phase drops the write
        tick(); ap(1'b1, 3'd2, 32'h30);
        tick(); idle(); HWDATA = 32'h55; HRESET = 1'b1; #1;
        chk("rw_wea", wea, 0);
        tick(); HRESET = 1'b0; ap(1'b0, 3'd2, 32'h30);
        tick(); idle(); #1;
        chk("rw_hrdata", HRDATA, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
